// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared definitions for the four-digit seven-segment display
// controller.
//   conv_state_t  - binary-to-BCD conversion FSM states
//   numofbits()   - width needed to count 0..n-1 (used to size the prescalers)
//   seg_encode()  - BCD digit to active-low segment pattern (g..a)
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam int BCD_ITERS     = 7;
    localparam int SCAN_DIV_DEF  = 50000;
    localparam int BLINK_DIV_DEF = 25000000;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int numofbits(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (((n - 1) >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

    localparam int SCAN_W_DEF  = numofbits(SCAN_DIV_DEF);
    localparam int BLINK_W_DEF = numofbits(BLINK_DIV_DEF);

    // Active-low segments, bit6 = g ... bit0 = a. Non-decimal codes blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'd0:    on = 7'h3F;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5B;
            4'd3:    on = 7'h4F;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6D;
            4'd6:    on = 7'h7D;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7F;
            4'd9:    on = 7'h6F;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

endpackage

// File: rtl/seg_display_bcd_conv.sv
// bcd_conv: iterative double-dabble converter, 7-bit binary (0..99) to two
// BCD digits, one iteration per clock.
//   clock, reset - system clock, async active-low reset
//   start        - load value and perform the first iteration
//   step         - perform one further iteration
//   value        - binary input (already clamped to 0..99)
//   tens, ones   - BCD result, valid after 7 iterations in total
module bcd_conv
    import seg_display_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // {tens[3:0], ones[3:0], binary[6:0]}
    logic [14:0] sr;

    function automatic logic [14:0] dabble(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7]  + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     sr <= '0;
        else if (start) sr <= dabble({8'd0, value});
        else if (step)  sr <= dabble(sr);
    end

    assign tens = sr[14:11];
    assign ones = sr[10:7];

endmodule

// File: rtl/seg_display.sv
// seg_display: captures two 0..99 values, converts them to four BCD digits
// and scans them onto a multiplexed common-anode display with per-digit blink
// and a blinking colon (decimal point of digit 2).
//   clock, reset        - system clock, async active-low reset
//   value_hi, value_lo  - binary pair values, clamped to 99 at capture
//   update              - capture/convert strobe (queued as pending while busy)
//   blink_mask, colon_en- per-digit blink enable, colon enable
//   seg_n, an_n, dp_n   - registered active-low display drive
//   busy                - conversion in progress
//
// Conversion FSM:
//   state    | meaning
//   ST_IDLE  | waiting for update or pending request; start captures values
//   ST_SHIFT | double-dabble iterations 2..7, one per clock
//   ST_DONE  | commit all four digits at once, return to idle
module seg_display
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] value_hi,
    input  logic [6:0] value_lo,
    input  logic       update,
    input  logic [3:0] blink_mask,
    input  logic       colon_en,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       dp_n,
    output logic       busy
);

    localparam int SCAN_W  = numofbits(SCAN_DIV);
    localparam int BLINK_W = numofbits(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_DIV - 1);

    conv_state_t state, state_nx;
    logic [2:0]  iter, iter_nx;
    logic        pending, pending_nx;
    logic        conv_start, conv_step, commit;

    logic [6:0]  hi_c, lo_c;
    logic [3:0]  hi_tens, hi_ones, lo_tens, lo_ones;
    logic [3:0]  digits [4];

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [1:0]         idx;
    logic               scan_on;
    logic               blink_phase;

    assign hi_c = (value_hi > 7'd99) ? 7'd99 : value_hi;
    assign lo_c = (value_lo > 7'd99) ? 7'd99 : value_lo;

    bcd_conv u_conv_hi (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .step  (conv_step),
        .value (hi_c),
        .tens  (hi_tens),
        .ones  (hi_ones)
    );

    bcd_conv u_conv_lo (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .step  (conv_step),
        .value (lo_c),
        .tens  (lo_tens),
        .ones  (lo_ones)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            iter    <= 3'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            iter    <= iter_nx;
            pending <= pending_nx;
        end
    end

    // The start cycle already performs the first iteration, so SHIFT covers
    // the remaining six and DONE only commits.
    always_comb begin
        state_nx   = state;
        iter_nx    = iter;
        pending_nx = pending;
        conv_start = 1'b0;
        conv_step  = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (update || pending) begin
                    conv_start = 1'b1;
                    pending_nx = 1'b0;
                    iter_nx    = 3'd1;
                    state_nx   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                conv_step = 1'b1;
                iter_nx   = iter + 3'd1;
                if (update) pending_nx = 1'b1;
                if (iter == 3'(BCD_ITERS - 1)) state_nx = ST_DONE;
            end
            ST_DONE: begin
                commit = 1'b1;
                if (update) pending_nx = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
        end else if (commit) begin
            digits[3] <= hi_tens;
            digits[2] <= hi_ones;
            digits[1] <= lo_tens;
            digits[0] <= lo_ones;
        end
    end

    // Display stays dark until the first scan terminal count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            scan_on  <= 1'b0;
        end else if (scan_cnt == SCAN_TC) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
            scan_on  <= 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_TC) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_n <= 7'h7F;
            an_n  <= 4'hF;
            dp_n  <= 1'b1;
        end else if (scan_on) begin
            an_n  <= ~(4'b0001 << idx);
            seg_n <= (blink_phase && blink_mask[idx]) ? 7'h7F : seg_encode(digits[idx]);
            dp_n  <= ~((idx == 2'd2) && colon_en && !blink_phase);
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: randomized scoreboard bench for seg_display with a fast
// scan/blink rate. A reference process predicts conversion starts and pushes
// expected digits; a monitor pops them when busy falls and checks every
// cycle's display drive against scan/blink arithmetic.
module tb_seg_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] value_hi = '0;
    logic [6:0] value_lo = '0;
    logic       update = 1'b0;
    logic [3:0] blink_mask = '0;
    logic       colon_en = 1'b0;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       dp_n;
    logic       busy;

    seg_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clock      (clock),
        .reset      (reset),
        .value_hi   (value_hi),
        .value_lo   (value_lo),
        .update     (update),
        .blink_mask (blink_mask),
        .colon_en   (colon_en),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    int          pops = 0;
    int          ecnt = 0;
    int          m_cnt = 0;
    bit          m_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // {digit3, digit2, digit1, digit0}
    function automatic logic [15:0] expect_digits(input int hi, input int lo);
        int h;
        int l;
        h = (hi > 99) ? 99 : hi;
        l = (lo > 99) ? 99 : lo;
        return {4'(h / 10), 4'(h % 10), 4'(l / 10), 4'(l % 10)};
    endfunction

    // Reference: a conversion occupies 7 cycles; requests during that time
    // collapse into one that starts the cycle after, using the values then.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ecnt   = 0;
            m_cnt  = 0;
            m_pend = 1'b0;
            exp_q.delete();
        end else begin
            ecnt++;
            if (m_cnt == 0) begin
                if (update || m_pend) begin
                    exp_q.push_back(expect_digits(int'(value_hi), int'(value_lo)));
                    m_cnt  = 7;
                    m_pend = 1'b0;
                end
            end else begin
                if (update) m_pend = 1'b1;
                m_cnt--;
            end
        end
    end

    logic [15:0] disp_prev = '0;
    logic [3:0]  mask_prev = '0;
    logic        colon_prev = 1'b0;
    logic        busy_prev = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          mon_j, mon_idx, mon_ph;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            disp_prev  = '0;
            busy_prev  = 1'b0;
            mask_prev  = blink_mask;
            colon_prev = colon_en;
        end else begin
            if (ecnt <= SCAN_DIV) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                mon_j   = ecnt - 1;
                mon_idx = (mon_j / SCAN_DIV) % 4;
                mon_ph  = (mon_j / BLINK_DIV) % 2;
                e_an    = 4'hF;
                e_an[mon_idx] = 1'b0;
                e_seg = (mon_ph == 1 && mask_prev[mon_idx]) ? 7'h7F
                                                           : seg_of(disp_prev[mon_idx*4 +: 4]);
                e_dp  = (mon_idx == 2 && colon_prev && mon_ph == 0) ? 1'b0 : 1'b1;
            end
            check("an_n", 32'(an_n), 32'(e_an));
            check("seg_n", 32'(seg_n), 32'(e_seg));
            check("dp_n", 32'(dp_n), 32'(e_dp));
            check("busy", 32'(busy), 32'(m_cnt != 0));
            if (busy_prev && !busy) begin
                check("sb_entry_present", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    disp_prev = exp_q.pop_front();
                    pops++;
                end
            end
            busy_prev  = busy;
            mask_prev  = blink_mask;
            colon_prev = colon_en;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        value_hi = 7'(hi);
        value_lo = 7'(lo);
        update   = 1'b1;
        tick(1);
        update   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
        check({tag, "_an_n"}, 32'(an_n), 32'hF);
        check({tag, "_dp_n"}, 32'(dp_n), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    int pops_before;

    initial begin
        #12;
        check_reset_outputs("reset_init");
        #11 reset = 1'b1;
        tick(2);

        // Latency and digit map
        pulse(59, 7);
        tick(40);

        // Clamp
        pulse(120, 100);
        tick(40);

        // Pending request with repeated strobes collapses into one
        pops_before = pops;
        pulse(12, 34);
        tick(2);
        pulse(45, 56);
        tick(1);
        pulse(45, 56);
        tick(40);
        check("pending_conversions", 32'(pops - pops_before), 32'd2);

        // Blink and colon
        blink_mask = 4'b1000;
        colon_en   = 1'b1;
        tick(200);
        blink_mask = 4'b0110;
        colon_en   = 1'b0;
        tick(100);
        blink_mask = 4'b0000;
        colon_en   = 1'b1;

        // Reset during SHIFT
        pulse(88, 77);
        tick(2);
        #1 reset = 1'b0;
        #1 check_reset_outputs("reset_mid");
        #1 reset = 1'b1;
        tick(40);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            blink_mask = 4'($urandom);
            colon_en   = 1'($urandom);
            pulse(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
            tick(int'($urandom_range(0, 14)));
        end
        tick(60);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
